// File: rtl/fpnew_result_rob.sv
// fpnew_result_rob: result-ordering buffer between the FPU opgroup blocks and
// the core writeback port. Each issued operation reserves a slot ID. Results come
// back by ID on any channel, in any order. They retire either in issue order or
// oldest-completed-first.
module fpnew_result_rob #(
  parameter int unsigned  NumChan  = 5,
  parameter int unsigned  Width    = 64,
  parameter int unsigned  Depth    = 8,
  parameter int unsigned  TagWidth = 1,
  parameter bit           InOrder  = 1'b1,
  localparam int unsigned IdW      = $clog2(Depth)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       alloc_valid_i,
  output logic                       alloc_ready_o,
  input  logic [TagWidth-1:0]        alloc_tag_i,
  output logic [IdW-1:0]             alloc_id_o,
  input  logic [NumChan-1:0]         ch_valid_i,
  output logic [NumChan-1:0]         ch_ready_o,
  input  logic [NumChan*IdW-1:0]     ch_id_i,
  input  logic [NumChan*Width-1:0]   ch_result_i,
  input  logic [NumChan*5-1:0]       ch_status_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           out_result_o,
  output logic [4:0]                 out_status_o,
  output logic [TagWidth-1:0]        out_tag_o,
  output logic [IdW-1:0]             out_id_o,
  output logic [IdW:0]               count_o,
  output logic                       busy_o
);

  localparam int unsigned PtrW = IdW + 1;
  localparam int unsigned ChW  = (NumChan > 1) ? $clog2(NumChan) : 1;

  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [Depth-1:0]    allocBits_q, allocBits_d;
  logic [Depth-1:0]    doneBits_q, doneBits_d;
  logic [Depth-1:0]    staleBits_q, staleBits_d;
  logic                lockValid_q, lockValid_d;
  logic [IdW-1:0]      lockIdx_q, lockIdx_d;
  logic [Width-1:0]    result_q [Depth];
  logic [4:0]          status_q [Depth];
  logic [TagWidth-1:0] tag_q [Depth];

  logic [PtrW-1:0]     count;
  logic                full, empty, allocFire, popFire, headAdv, selFound, badWrite;
  logic [IdW-1:0]      headIdx, tailIdx, selIdx, scanIdx, wrId, dupId;
  logic [Depth-1:0]    wrEn;
  logic [ChW-1:0]      wrSel [Depth];

  assign count   = tail_q - head_q;
  assign full    = (count == PtrW'(Depth));
  assign empty   = (count == '0);
  assign headIdx = head_q[IdW-1:0];
  assign tailIdx = tail_q[IdW-1:0];

  assign alloc_ready_o = ~full & ~flush_i;
  assign alloc_id_o    = tailIdx;
  assign allocFire     = alloc_valid_i & alloc_ready_o;
  assign ch_ready_o    = {NumChan{~flush_i}};

  // Pick the slot to retire: head only when in order, otherwise the first completed
  // slot scanning from head, frozen while the core is stalling a presented result.
  always_comb begin
    selFound = 1'b0;
    selIdx   = headIdx;
    scanIdx  = headIdx;
    if (InOrder) begin
      selFound = ~empty & allocBits_q[headIdx] & doneBits_q[headIdx];
    end else if (lockValid_q) begin
      selFound = 1'b1;
      selIdx   = lockIdx_q;
    end else begin
      for (int k = Depth - 1; k >= 0; k--) begin
        scanIdx = headIdx + IdW'(k);
        if ((PtrW'(k) < count) && allocBits_q[scanIdx] && doneBits_q[scanIdx]) begin
          selFound = 1'b1;
          selIdx   = scanIdx;
        end
      end
    end
  end

  assign out_valid_o  = selFound & ~flush_i;
  assign popFire      = out_valid_o & out_ready_i;
  assign out_result_o = out_valid_o ? result_q[selIdx] : '0;
  assign out_status_o = out_valid_o ? status_q[selIdx] : '0;
  assign out_tag_o    = out_valid_o ? tag_q[selIdx]    : '0;
  assign out_id_o     = out_valid_o ? selIdx           : '0;
  assign count_o      = count;
  assign busy_o       = (count != '0);

  // Decide which channel writes each slot; descending scan lets the lowest channel win
  // on an ID collision. Writes to stale slots left over from a flush drop silently.
  always_comb begin
    wrEn     = '0;
    badWrite = 1'b0;
    wrId     = '0;
    dupId    = '0;
    for (int s = 0; s < Depth; s++) wrSel[s] = '0;
    for (int c = NumChan - 1; c >= 0; c--) begin
      wrId = ch_id_i[c*IdW +: IdW];
      if (ch_valid_i[c] && !flush_i) begin
        if (allocBits_q[wrId] && !doneBits_q[wrId]) begin
          wrEn[wrId]  = 1'b1;
          wrSel[wrId] = ChW'(c);
        end else if (allocBits_q[wrId] || !staleBits_q[wrId]) begin
          badWrite = 1'b1;
        end
        for (int o = 0; o < c; o++) begin
          dupId = ch_id_i[o*IdW +: IdW];
          if (ch_valid_i[o] && (dupId == wrId)) badWrite = 1'b1;
        end
      end
    end
  end

  // Next-state for pointers, slot flags and the stall lock.
  always_comb begin
    headAdv     = ~empty & ((popFire & (selIdx == headIdx)) | ~allocBits_q[headIdx]);
    head_d      = head_q + {{IdW{1'b0}}, headAdv};
    tail_d      = tail_q + {{IdW{1'b0}}, allocFire};
    allocBits_d = allocBits_q;
    doneBits_d  = doneBits_q | wrEn;
    staleBits_d = staleBits_q;
    lockValid_d = out_valid_o & ~out_ready_i;
    lockIdx_d   = selIdx;
    if (popFire) begin
      allocBits_d[selIdx] = 1'b0;
      doneBits_d[selIdx]  = 1'b0;
    end
    if (allocFire) begin
      allocBits_d[tailIdx] = 1'b1;
      doneBits_d[tailIdx]  = 1'b0;
      staleBits_d[tailIdx] = 1'b0;
    end
  end

  // Control state; flush empties the buffer and marks live slots stale.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      allocBits_q <= '0;
      doneBits_q  <= '0;
      staleBits_q <= '0;
      lockValid_q <= 1'b0;
      lockIdx_q   <= '0;
    end else if (flush_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      allocBits_q <= '0;
      doneBits_q  <= '0;
      staleBits_q <= staleBits_q | allocBits_q;
      lockValid_q <= 1'b0;
      lockIdx_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      allocBits_q <= allocBits_d;
      doneBits_q  <= doneBits_d;
      staleBits_q <= staleBits_d;
      lockValid_q <= lockValid_d;
      lockIdx_q   <= lockIdx_d;
    end
  end

  // Slot payload storage: results/status from the winning channel, tag at issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < Depth; s++) begin
        result_q[s] <= '0;
        status_q[s] <= '0;
        tag_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < Depth; s++) begin
        if (wrEn[s]) begin
          result_q[s] <= ch_result_i[int'(wrSel[s])*Width +: Width];
          status_q[s] <= ch_status_i[int'(wrSel[s])*5 +: 5];
        end
      end
      if (allocFire) tag_q[tailIdx] <= alloc_tag_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !badWrite);

endmodule
